// File: rtl/bit_serial_adder_pkg.sv
// Shared types for the bit-serial adder.
package bit_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bit_serial_adder_fa.sv
// Single-bit full-adder cell driven by the serial adder each cycle.
module bit_serial_adder_fa (
    input  logic A,
    input  logic B,
    input  logic X,
    output logic S,
    output logic C
);

    // Sum and carry of one bit position.
    assign S = A ^ B ^ X;
    assign C = (A & B) | (X & (A ^ B));

endmodule

// File: rtl/bit_serial_adder.sv
// LSB-first bit-serial adder: one full-adder cell, registered carry loop,
// valid/ready handshakes on the operand and result sides.
module bit_serial_adder
    import bit_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             OVF,
    output logic             BUSY
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic               fa_s;
    logic               fa_c;
    logic [WIDTH:0]     sum_ext;
    logic               last_bit;

    bit_serial_adder_fa u_fa (
        .A (a_sr_q[0]),
        .B (b_sr_q[0]),
        .X (carry_q),
        .S (fa_s),
        .C (fa_c)
    );

    // New sum bit enters at the MSB; dropping bit 0 also works for WIDTH=1.
    assign sum_ext  = {fa_s, sum_sr_q};
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // State and datapath registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            sum_sr_q    <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sr_q      <= a_sr_d;
            b_sr_q      <= b_sr_d;
            sum_sr_q    <= sum_sr_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
        end
    end

    // Next-state and next-register logic; every register holds by default.
    always_comb begin
        state_d     = state_q;
        a_sr_d      = a_sr_q;
        b_sr_d      = b_sr_q;
        sum_sr_d    = sum_sr_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;

        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (IN_VALID && in_ready_q) begin
                    a_sr_d     = A;
                    b_sr_d     = B;
                    carry_d    = CIN;
                    cnt_d      = '0;
                    sum_sr_d   = '0;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                sum_sr_d = sum_ext[WIDTH:1];
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                carry_d  = fa_c;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    sum_d       = sum_ext[WIDTH:1];
                    cout_d      = fa_c;
                    // carry_q is the carry into the MSB at this point
                    ovf_d       = carry_q ^ fa_c;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (OUT_READY) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = out_valid_q;
    assign BUSY      = busy_q;
    assign SUM       = sum_q;
    assign COUT      = cout_q;
    assign OVF       = ovf_q;

endmodule

// File: doc/bit_serial_adder.md
Name: bit_serial_adder

Overview:
Sequential adder that takes two WIDTH-bit operands in parallel and adds them LSB-first, one bit per clock, through a single FullAdder cell with a registered carry loop. It sits directly upstream of the FullAdder. It feeds A, B and the carry-in X on each cycle and consumes S and C. It also supplies the operand-side and result-side valid/ready handshakes the combinational cell lacks.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range is 1 or more.
CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
CLK        input   1      rising-edge clock
RST_N      input   1      asynchronous active-low reset
IN_VALID   input   1      operands A, B, CIN valid
IN_READY   output  1      block can accept operands; registered
A          input   WIDTH  operand A; sampled only on accept
B          input   WIDTH  operand B; sampled only on accept
CIN        input   1      carry-in; sampled only on accept
OUT_VALID  output  1      SUM, COUT, OVF valid; registered
OUT_READY  input   1      consumer accepts the result
SUM        output  WIDTH  A+B+CIN, modulo 2^WIDTH
COUT       output  1      unsigned carry-out
OVF        output  1      two's-complement signed overflow
BUSY       output  1      high in RUN or DONE

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low on RST_N.
- Reset values while RST_N is low:
  - State is IDLE.
  - IN_READY=0, OUT_VALID=0, BUSY=0.
  - SUM, COUT, OVF are 0.
  - All shift registers, carry_q and the counter are 0.
- IN_READY rises on the first CLK edge after RST_N deasserts.
- The state machine has three states: IDLE, RUN, DONE.
- IDLE:
  - IN_READY=1.
  - Accept occurs at an edge where IN_VALID&&IN_READY.
  - On accept: a_sr<=A, b_sr<=B, carry_q<=CIN, cnt<=0, sum_sr<=0, IN_READY<=0; go to RUN.
- RUN (exactly WIDTH cycles):
  - FullAdder inputs are A=a_sr[0], B=b_sr[0], X=carry_q.
  - Each edge:
    - sum_sr<={S, sum_sr[WIDTH-1:1]}
    - a_sr and b_sr shift right by 1
    - carry_q<=C
    - cnt<=cnt+1
  - At the edge where cnt==WIDTH-1:
    - SUM<=final shifted sum_sr
    - COUT<=C
    - OVF<=carry_q^C, where carry_q is the carry into the MSB
    - OUT_VALID<=1; go to DONE
- Latency: if accept happens at edge t, OUT_VALID is high after edge t+WIDTH.
- DONE:
  - SUM, COUT and OVF are held stable while OUT_VALID=1.
  - At an edge with OUT_READY=1: OUT_VALID<=0, IN_READY<=1; go to IDLE.
  - OUT_READY low holds DONE indefinitely.
- SUM, COUT and OVF keep their last values after leaving DONE until the next completion. They are meaningful only while OUT_VALID=1.
- IN_VALID is ignored outside IDLE. Operand changes after accept have no effect.
- Maximum throughput is one addition per WIDTH+2 cycles: accept, WIDTH RUN cycles, DONE→IDLE.
- WIDTH=1: RUN lasts one cycle; OVF=CIN^COUT.
- Reset mid-RUN or mid-DONE aborts the operation immediately. No OUT_VALID pulse is produced, and all registers return to reset values.
- No combinational path from any input to any output.

Decomposition:
- Package bit_serial_adder_pkg holds the 2-bit state_t enum: IDLE=0, RUN=1, DONE=2.
- Sub-module: one instance of the existing FullAdder cell (A, B, X, S, C).
- The rest is the FSM, the counter, the shift registers and carry_q in the top module.

Test Plan:
1. WIDTH=8, A=0x0F, B=0x01, CIN=0 → SUM=0x10, COUT=0, OVF=0. OUT_VALID rises exactly 8 cycles after accept.
2. A=0xFF, B=0x01, CIN=0 → SUM=0x00, COUT=1, OVF=0. A=0x7F, B=0x01 → SUM=0x80, COUT=0, OVF=1.
3. A=0x80, B=0x80, CIN=0 → SUM=0x00, COUT=1, OVF=1. A=0xFF, B=0x00, CIN=1 → SUM=0x00, COUT=1, OVF=0.
4. Backpressure: OUT_READY low for 5 cycles in DONE → SUM, COUT, OVF and OUT_VALID held; IN_READY=0. An IN_VALID pulse with A=0x11 is ignored. OUT_READY=1 → IDLE next cycle, and the next result is unaffected.
5. Reset asserted at RUN cycle 3 of 0x55+0xAA → all outputs 0 asynchronously. After release IN_READY=1 one edge later, and a fresh 0x01+0x01 gives SUM=0x02 with no stale OUT_VALID.
6. WIDTH=4 and WIDTH=1 builds: exhaustive A, B, CIN with random OUT_READY delays → all results match a reference model of A+B+CIN, COUT and signed overflow.
